// File: rtl/mac_pe.sv
// mac_pe -- multiply-accumulate processing element for a systolic array.
//
// Purpose: registers ain*bin each cycle (stage 1). It then accumulates K
// valid products into an ACC_W-bit accumulator after each start pulse. It
// also forwards the operands and their valid flag to the neighbouring
// element one cycle later.
//
// Optional build macro: MAC_PE_SAT_EN. When defined, an overflowing addition
// clamps the accumulator to all-ones. When undefined, the accumulator wraps.
// In both builds, ovf is sticky until the next start or reset.
//
// Ports:
//   clk       in   sole clock, rising edge
//   rst_n     in   asynchronous reset, active low
//   start     in   pulse: clear accumulator/ovf/count and begin accumulating
//   in_valid  in   ain/bin form a valid operand pair
//   ain, bin  in   unsigned operands, DATA_W bits
//   apass     out  ain delayed one cycle
//   bpass     out  bin delayed one cycle
//   vpass     out  in_valid delayed one cycle
//   out       out  accumulator value, ACC_W bits
//   done      out  one-cycle pulse after the K-th product is accumulated
//   ovf       out  sticky overflow flag for the current accumulation
module mac_pe #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned K      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] ain,
  input  logic [DATA_W-1:0] bin,
  output logic [DATA_W-1:0] apass,
  output logic [DATA_W-1:0] bpass,
  output logic              vpass,
  output logic [ACC_W-1:0]  out,
  output logic              done,
  output logic              ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [15:0] K_L = 16'(K);

  state_e                state_q, state_d;
  logic [DATA_W-1:0]     apass_q, bpass_q;
  logic                  vpass_q;
  logic [2*DATA_W-1:0]   prod_q;
  logic                  prodv_q;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic                  ovf_q, ovf_d;
  logic                  done_q, done_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [ACC_W:0]        sum;

  // Pass-through and multiplier stage run every cycle regardless of state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      apass_q <= '0;
      bpass_q <= '0;
      vpass_q <= 1'b0;
      prod_q  <= '0;
      prodv_q <= 1'b0;
    end else begin
      apass_q <= ain;
      bpass_q <= bin;
      vpass_q <= in_valid;
      prod_q  <= ain * bin;
      prodv_q <= in_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    // One extra bit captures the carry out of the accumulator.
    sum     = (ACC_W+1)'(acc_q) + (ACC_W+1)'(prod_q);
    if (start) begin
      // The product registered on this edge belongs to the new operands,
      // so the stale stage-1 product is dropped rather than accumulated.
      state_d = RUN;
      acc_d   = '0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (prodv_q) begin
            cnt_d = cnt_q + 16'd1;
`ifdef MAC_PE_SAT_EN
            acc_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
            acc_d = sum[ACC_W-1:0];
`endif
            if (sum[ACC_W]) ovf_d = 1'b1;
            if (cnt_q == K_L - 16'd1) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign apass = apass_q;
  assign bpass = bpass_q;
  assign vpass = vpass_q;
  assign out   = acc_q;
  assign done  = done_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_mac_pe.sv
module tb_mac_pe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  ain = '0;
  logic [7:0]  bin = '0;

  logic [7:0]  apass1, bpass1, apass2, bpass2;
  logic        vpass1, vpass2, done1, done2, ovf1, ovf2;
  logic [23:0] out1;
  logic [15:0] out2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mac_pe u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .ain(ain), .bin(bin), .apass(apass1), .bpass(bpass1), .vpass(vpass1),
    .out(out1), .done(done1), .ovf(ovf1)
  );

  mac_pe #(.DATA_W(8), .ACC_W(16), .K(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .ain(ain), .bin(bin), .apass(apass2), .bpass(bpass2), .vpass(vpass2),
    .out(out2), .done(done2), .ovf(ovf2)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: per instance, the exact (unbounded) sum of the valid products
  // accepted since start, plus the count of terms taken.
  int     kk[2] = '{8, 2};
  int     aw[2] = '{24, 16};
  bit     m_act[2];
  int     m_n[2];
  longint m_S[2];
  bit     m_done[2];
  bit     m_pv;
  longint m_pa, m_pb;
  longint e_ap, e_bp;
  bit     e_vp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i] = 0; m_n[i] = 0; m_S[i] = 0; m_done[i] = 0;
      end
      m_pv = 0; m_pa = 0; m_pb = 0; e_ap = 0; e_bp = 0; e_vp = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_done[i] = 0;
        if (start) begin
          m_act[i] = 1; m_n[i] = 0; m_S[i] = 0;
        end else if (m_act[i] && m_pv) begin
          m_S[i] += m_pa * m_pb;
          m_n[i]++;
          if (m_n[i] == kk[i]) begin
            m_act[i] = 0; m_done[i] = 1;
          end
        end
      end
      m_pv = in_valid; m_pa = ain; m_pb = bin;
      e_ap = ain; e_bp = bin; e_vp = in_valid;
    end
  end

  function automatic longint exp_out(input int i);
    longint mx = (longint'(1) << aw[i]) - 1;
`ifdef MAC_PE_SAT_EN
    return (m_S[i] > mx) ? mx : m_S[i];
`else
    return m_S[i] % (mx + 1);
`endif
  endfunction

  function automatic longint exp_ovf(input int i);
    return (m_S[i] > ((longint'(1) << aw[i]) - 1)) ? 1 : 0;
  endfunction

  // Every-cycle comparison, #1 after the active edge.
  bit  chk_en = 0;
  int  ncyc = 0, e0 = 0, lat = -1, done_cnt = 0;

  always @(posedge clk) begin
    #1;
    ncyc++;
    if (start) e0 = ncyc;
    if (done1) begin lat = ncyc - e0; done_cnt++; end
    if (chk_en) begin
      chk("out1", out1, exp_out(0));
      chk("ovf1", ovf1, exp_ovf(0));
      chk("done1", done1, m_done[0]);
      chk("apass1", apass1, e_ap);
      chk("bpass1", bpass1, e_bp);
      chk("vpass1", vpass1, e_vp);
      chk("out2", out2, exp_out(1));
      chk("ovf2", ovf2, exp_ovf(1));
      chk("done2", done2, m_done[1]);
      chk("vpass2", vpass2, e_vp);
    end
  end

  task automatic cyc(input bit st, input bit v, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    start = st; in_valid = v; ain = a; bin = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 8'd0, 8'd0);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_out", out1, 0);
    chk("rst_done", done1, 0);
    chk("rst_ovf", ovf1, 0);
    chk("rst_vpass", vpass1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1;
    idle(2);

    // 1..8 x 2 back-to-back: 72, done 8 edges after start edge
    lat = -1;
    cyc(1, 1, 8'd1, 8'd2);
    for (int i = 2; i <= 8; i++) cyc(0, 1, 8'(i), 8'd2);
    idle(3);
    chk("t1_out", out1, 72);
    chk("t1_ovf", ovf1, 0);
    chk("t1_lat", lat, 8);
    chk("t1_model", exp_out(0), 72);

    // 255x255 x8 with two bubbles: 520200, done two cycles later
    lat = -1;
    cyc(1, 1, 8'd255, 8'd255);
    for (int i = 1; i < 10; i++) begin
      if (i == 3 || i == 6) cyc(0, 0, 8'd255, 8'd255);
      else cyc(0, 1, 8'd255, 8'd255);
    end
    idle(3);
    chk("t2_out", out1, 520200);
    chk("t2_ovf", ovf1, 0);
    chk("t2_lat", lat, 10);

    // Narrow instance (ACC_W=16, K=2): 255x255 twice overflows
    cyc(1, 1, 8'd255, 8'd255);
    cyc(0, 1, 8'd255, 8'd255);
    idle(3);
    chk("t3_ovf", ovf2, 1);
`ifdef MAC_PE_SAT_EN
    chk("t3_out", out2, 65535);
`else
    chk("t3_out", out2, 64514);
`endif

    // Restart after 3 terms, then 8 pairs 1x1: earlier terms lost
    cyc(1, 1, 8'd7, 8'd7);
    cyc(0, 1, 8'd7, 8'd7);
    cyc(0, 1, 8'd7, 8'd7);
    cyc(0, 0, 8'd0, 8'd0);
    done_cnt = 0;
    cyc(1, 1, 8'd1, 8'd1);
    for (int i = 1; i < 8; i++) cyc(0, 1, 8'd1, 8'd1);
    idle(4);
    chk("t4_out", out1, 8);
    chk("t4_done_cnt", done_cnt, 1);
    chk("t4_ovf", ovf1, 0);

    // Pass-through while not running
    cyc(0, 1, 8'h5A, 8'hC3);
    @(posedge clk); #1;
    chk("t5_apass", apass1, 8'h5A);
    chk("t5_bpass", bpass1, 8'hC3);
    chk("t5_vpass", vpass1, 1);
    chk("t5_out_held", out1, 8);

    // Reset mid-RUN: immediate zero, then IDLE ignoring valid data
    cyc(1, 1, 8'd9, 8'd9);
    cyc(0, 1, 8'd9, 8'd9);
    cyc(0, 1, 8'd9, 8'd9);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_out", out1, 0);
    chk("t6_apass", apass1, 0);
    chk("t6_bpass", bpass1, 0);
    chk("t6_vpass", vpass1, 0);
    chk("t6_done", done1, 0);
    chk("t6_ovf", ovf1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) cyc(0, 1, 8'd9, 8'd9);
    idle(2);
    chk("t6_idle_out", out1, 0);
    chk("t6_idle_done", done_cnt, 0);

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
